// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory controller: FSM encodings,
// default geometry and the NOP instruction returned for rejected fetches.
package imem_pkg;

    localparam int IMEM_DEPTH = 16;
    localparam int IMEM_AW    = 12;
    localparam int IMEM_DW    = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: loads a program from a streaming loader, then
// serves CPU fetches. Define IMEM_BOUNDS_CHECK_EN to reject fetches >= DEPTH.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW,
    parameter int DW    = IMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW-1:0] ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          run_start,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_data,
    output logic          fetch_err,
    output logic          cpu_run,
    output logic          load_done,
    output logic [AW-1:0] ld_count,
    output logic          we_im,
    output logic [AW-1:0] add_im,
    output logic [DW-1:0] data_im_in,
    input  logic [DW-1:0] out_im
);

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
    localparam logic [AW-1:0] ONE     = AW'(1);

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] len_reg, len_next;
    logic [AW-1:0] ld_count_reg, ld_count_next;
    logic          load_done_reg, load_done_next;
    logic          fetch_valid_reg;
    logic          fetch_oob_reg;
    logic [AW-1:0] len_clamped;
    logic          wr_fire, rd_fire, rd_oob;

    assign len_clamped = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;

    // ready drops once the latched length is reached, so a zero-length load never accepts
    assign ld_ready = (state_reg == LOAD) && (ld_count_reg < len_reg);
    assign wr_fire  = ld_ready && ld_valid && !load_start && !rst;
    assign rd_fire  = (state_reg == RUN) && fetch_req && !rst;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign rd_oob    = (fetch_addr >= DEPTH_W);
    assign fetch_err = fetch_valid_reg && fetch_oob_reg;
`else
    assign rd_oob    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        we_im      = 1'b0;
        add_im     = '0;
        data_im_in = '0;
        if (wr_fire) begin
            we_im      = 1'b1;
            add_im     = ld_count_reg;
            data_im_in = ld_data;
        end else if (rd_fire && !rd_oob) begin
            add_im = fetch_addr;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        ld_count_next  = ld_count_reg;
        load_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    state_next    = LOAD;
                    len_next      = len_clamped;
                    ld_count_next = '0;
                end else if (run_start) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (load_start) begin
                    len_next      = len_clamped;
                    ld_count_next = '0;
                end else if (len_reg == '0) begin
                    state_next     = RUN;
                    load_done_next = 1'b1;
                end else if (wr_fire) begin
                    if (ld_count_reg < DEPTH_W) begin
                        ld_count_next = ld_count_reg + ONE;
                    end
                    if (ld_count_reg + ONE == len_reg) begin
                        state_next     = RUN;
                        load_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next    = LOAD;
                    len_next      = len_clamped;
                    ld_count_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            ld_count_reg    <= '0;
            load_done_reg   <= 1'b0;
            fetch_valid_reg <= 1'b0;
            fetch_oob_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            len_reg         <= len_next;
            ld_count_reg    <= ld_count_next;
            load_done_reg   <= load_done_next;
            fetch_valid_reg <= rd_fire;
            fetch_oob_reg   <= rd_fire && rd_oob;
        end
    end

    assign cpu_run     = (state_reg == RUN);
    assign load_done   = load_done_reg;
    assign ld_count    = ld_count_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_data  = (fetch_valid_reg && !fetch_oob_reg) ? out_im : DW'(NOP);

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a behavioural instruction memory and
// write/fetch scoreboards; build with IMEM_BOUNDS_CHECK_EN to cover bounds checking.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [11:0] ld_len;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        run_start;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        fetch_err;
    logic        cpu_run;
    logic        load_done;
    logic [11:0] ld_count;
    logic        we_im;
    logic [11:0] add_im;
    logic [15:0] data_im_in;
    logic [15:0] out_im;

    always #5 clk = ~clk;

    imem_ctrl dut (
        .clk(clk), .rst(rst), .load_start(load_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .run_start(run_start), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .cpu_run(cpu_run), .load_done(load_done), .ld_count(ld_count),
        .we_im(we_im), .add_im(add_im), .data_im_in(data_im_in), .out_im(out_im)
    );

    // behavioural instruction memory with registered read
    logic [15:0] mem [0:4095] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (we_im) mem[add_im] <= data_im_in;
        out_im <= mem[add_im];
    end

    typedef struct { logic [11:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] data; logic err; int due; } rd_t;

    wr_t         wq[$];
    rd_t         fq[$];
    logic [15:0] exp_mem [0:4095] = '{default: 16'h0000};
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
        exp_mem[a] = d;
    endtask

    task automatic push_rd(input logic [15:0] d, input logic e);
        rd_t r;
        r.data = d;
        r.err  = e;
        r.due  = cyc_cnt + 1;
        fq.push_back(r);
    endtask

    // one clock: check bus/return activity mid-cycle, then step past the edge
    task automatic cyc();
        wr_t w;
        rd_t r;
        @(negedge clk);
        if (we_im === 1'b1) begin
            if (wq.size() == 0) check("unexpected_write", 32'(we_im), 32'd0);
            else begin
                w = wq.pop_front();
                check("wr_addr", 32'(add_im), 32'(w.addr));
                check("wr_data", 32'(data_im_in), 32'(w.data));
            end
        end
        if (fetch_valid === 1'b1) begin
            if (fq.size() == 0) check("unexpected_fetch_valid", 32'(fetch_valid), 32'd0);
            else begin
                r = fq.pop_front();
                check("fetch_latency", 32'(cyc_cnt), 32'(r.due));
                check("fetch_data", 32'(fetch_data), 32'(r.data));
                check("fetch_err", 32'(fetch_err), 32'(r.err));
            end
        end
        @(posedge clk);
        cyc_cnt++;
        #1;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        run_start = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        cyc(); cyc();
        check("rst_cpu_run", 32'(cpu_run), 0);
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_fetch_valid", 32'(fetch_valid), 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_we_im", 32'(we_im), 0);
        check("rst_ld_count", 32'(ld_count), 0);
        check("rst_add_im", 32'(add_im), 0);
        check("rst_data_im_in", 32'(data_im_in), 0);
        rst = 1'b0;

        // load 4 words; load_start wins over run_start
        load_start = 1'b1; run_start = 1'b1; ld_len = 12'd4;
        cyc();
        load_start = 1'b0; run_start = 1'b0;
        check("load_cpu_run", 32'(cpu_run), 0);
        check("load_ld_ready", 32'(ld_ready), 1);
        check("load_ld_count0", 32'(ld_count), 0);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data = 16'(32'h1111 * (i + 1));
            push_wr(12'(i), ld_data);
            cyc();
        end
        ld_valid = 1'b0;
        check("load_done_pulse", 32'(load_done), 1);
        check("load_cpu_run_on", 32'(cpu_run), 1);
        check("load_ld_count4", 32'(ld_count), 4);
        check("load_ld_ready_run", 32'(ld_ready), 0);
        cyc();
        check("load_done_drop", 32'(load_done), 0);

        // back-to-back fetches
        for (int a = 0; a < 4; a++) begin
            fetch_req = 1'b1;
            fetch_addr = 12'(a);
            push_rd(exp_mem[a], 1'b0);
            #1;
            check("fetch_add_im", 32'(add_im), 32'(a));
            check("fetch_we_im", 32'(we_im), 0);
            cyc();
        end
        fetch_req = 1'b0;
        cyc();
        check("fetch_drained", 32'(fq.size()), 0);

        // abort RUN with a fetch in flight, then gapped load clamped to 16
        load_start = 1'b1; ld_len = 12'd20; fetch_req = 1'b1; fetch_addr = 12'd2;
        push_rd(exp_mem[2], 1'b0);
        cyc();
        load_start = 1'b0; fetch_req = 1'b0;
        check("abort_cpu_run", 32'(cpu_run), 0);
        check("abort_ld_count", 32'(ld_count), 0);
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_data = 16'(16'hA000 + i);
            push_wr(12'(i), ld_data);
            cyc();
            ld_valid = 1'b0;
            if (i < 15) begin
                if (i == 3) begin
                    fetch_req = 1'b1;
                    fetch_addr = 12'd5;
                end
                #1;
                check("gap_we_im", 32'(we_im), 0);
                check("gap_add_im", 32'(add_im), 0);
                cyc();
                fetch_req = 1'b0;
            end
        end
        check("clamp_cpu_run", 32'(cpu_run), 1);
        check("clamp_load_done", 32'(load_done), 1);
        check("clamp_ld_count", 32'(ld_count), 16);
        ld_valid = 1'b1;
        cyc();
        ld_valid = 1'b0;
        check("clamp_no_wrap", 32'(ld_count), 16);
        check("clamp_writes", 32'(wq.size()), 0);

        // restart a load after two words
        load_start = 1'b1; ld_len = 12'd4;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data = 16'(16'hBE00 + i);
            push_wr(12'(i), ld_data);
            cyc();
        end
        check("restart_pre_count", 32'(ld_count), 2);
        load_start = 1'b1; ld_data = 16'hDEAD;
        #1;
        check("restart_no_write", 32'(we_im), 0);
        cyc();
        load_start = 1'b0;
        check("restart_count", 32'(ld_count), 0);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data = 16'(16'h5000 + i);
            push_wr(12'(i), ld_data);
            cyc();
        end
        ld_valid = 1'b0;
        check("restart_done", 32'(load_done), 1);
        fetch_req = 1'b1; fetch_addr = 12'd0; push_rd(exp_mem[0], 1'b0);
        cyc();
        fetch_addr = 12'd3; push_rd(exp_mem[3], 1'b0);
        cyc();
        fetch_req = 1'b0;
        cyc();

        // reset in the middle of a load
        load_start = 1'b1; ld_len = 12'd4;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data = 16'(16'h7001 + i);
            push_wr(12'(i), ld_data);
            cyc();
        end
        rst = 1'b1; ld_data = 16'h7003;
        #1;
        check("rstload_no_write", 32'(we_im), 0);
        cyc();
        rst = 1'b0; ld_valid = 1'b0;
        check("rstload_cpu_run", 32'(cpu_run), 0);
        check("rstload_ld_ready", 32'(ld_ready), 0);
        check("rstload_ld_count", 32'(ld_count), 0);
        run_start = 1'b1;
        cyc();
        run_start = 1'b0;
        check("runstart_cpu_run", 32'(cpu_run), 1);
        check("runstart_load_done", 32'(load_done), 0);
        fetch_req = 1'b1; fetch_addr = 12'd1; push_rd(exp_mem[1], 1'b0);
        cyc();
        fetch_req = 1'b0;
        cyc();

        // reset in RUN discards the pending return
        fetch_req = 1'b1; fetch_addr = 12'd0; rst = 1'b1;
        cyc();
        fetch_req = 1'b0; rst = 1'b0;
        check("rstrun_fetch_valid", 32'(fetch_valid), 0);
        check("rstrun_cpu_run", 32'(cpu_run), 0);
        cyc();

        // zero-length load
        load_start = 1'b1; ld_len = 12'd0;
        cyc();
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h9999;
        check("len0_cpu_run_off", 32'(cpu_run), 0);
        cyc();
        ld_valid = 1'b0;
        check("len0_cpu_run", 32'(cpu_run), 1);
        check("len0_load_done", 32'(load_done), 1);
        check("len0_ld_count", 32'(ld_count), 0);

        // out-of-range fetch followed by an in-range one
        fetch_req = 1'b1; fetch_addr = 12'd16;
`ifdef IMEM_BOUNDS_CHECK_EN
        push_rd(16'h0000, 1'b1);
        #1;
        check("oob_add_im", 32'(add_im), 0);
`else
        push_rd(exp_mem[16], 1'b0);
        #1;
`endif
        check("oob_we_im", 32'(we_im), 0);
        cyc();
        fetch_addr = 12'd0; push_rd(exp_mem[0], 1'b0);
        cyc();
        fetch_req = 1'b0;
        cyc();

        check("final_wq_empty", 32'(wq.size()), 0);
        check("final_fq_empty", 32'(fq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter: DEPTH, 16, number of instruction-memory words.
REQ-002 Parameter: AW, 12, address width.
REQ-003 Parameter: DW, 16, instruction width.
REQ-004 Clock and reset: one clock, clk; reset rst, synchronous, active-high.
REQ-005 Port list (name, direction, width, meaning):
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
  - load_start  in  1  pulse: begin program load.
  - ld_len  in  AW  words to load, sampled with load_start.
  - ld_valid  in  1  loader word valid.
  - ld_data  in  DW  loader word.
  - ld_ready  out  1  controller accepts loader word.
  - run_start  in  1  pulse: enter RUN without loading.
  - fetch_req  in  1  CPU fetch request.
  - fetch_addr  in  AW  fetch address.
  - fetch_valid  out  1  fetch_data valid.
  - fetch_data  out  DW  fetched instruction.
  - fetch_err  out  1  out-of-range fetch (only when IMEM_BOUNDS_CHECK_EN is defined).
  - cpu_run  out  1  CPU may execute.
  - load_done  out  1  one-cycle pulse at end of load.
  - ld_count  out  AW  words written so far in the current load.
  - we_im  out  1  memory write enable.
  - add_im  out  AW  memory address.
  - data_im_in  out  DW  memory write data.
  - out_im  in  DW  memory registered read data.

Function
REQ-006 States: IDLE, LOAD, RUN.
REQ-007 IDLE: load_start goes to LOAD; run_start goes to RUN; load_start wins if both are asserted.
REQ-008 On entering LOAD: ld_count cleared to 0; ld_len latched, clamped to DEPTH if larger.
REQ-009 LOAD: ld_ready=1; each cycle with ld_valid&&ld_ready drives we_im=1, add_im=ld_count, data_im_in=ld_data, then increments ld_count.
REQ-010 LOAD completion: the accepted word with ld_count==len-1 causes a transition to RUN on the next edge, with load_done=1 for exactly that first RUN cycle.
REQ-011 Latched ld_len==0: transition directly from LOAD to RUN after one cycle, with no writes and load_done pulsed.
REQ-012 load_start asserted in LOAD restarts the load: ld_count=0, ld_len re-latched, no write that cycle.
REQ-013 load_start asserted in RUN aborts RUN: go to LOAD, cpu_run=0 next cycle; any fetch issued that cycle still completes.
REQ-014 cpu_run=1 exactly while in RUN.
REQ-015 RUN fetch issue: fetch_req drives we_im=0 and add_im=fetch_addr combinationally in the same cycle.
REQ-016 RUN fetch return: fetch_valid=1 and fetch_data=out_im on the following cycle (latency 1, one fetch per cycle, back-to-back allowed).
REQ-017 Outside RUN, fetch_req is ignored: no fetch_valid follows it.
REQ-018 In LOAD, ld_ready=0 in IDLE and RUN; ld_valid is ignored there.
REQ-019 Idle bus: when no write or fetch is in progress, we_im=0, add_im=0 and data_im_in=0.
REQ-020 ld_count saturates at DEPTH and never wraps.

Reset
REQ-021 rst asserted at any edge forces state=IDLE and sets cpu_run, ld_ready, fetch_valid, fetch_err, load_done, we_im, ld_count and add_im all to 0.
REQ-022 rst during LOAD abandons the partial load without further writes; memory contents are not cleared.
REQ-023 rst during RUN discards any pending fetch_valid.

Configuration
REQ-024 Macro IMEM_BOUNDS_CHECK_EN, when defined: a fetch with fetch_addr>=DEPTH drives no memory access; one cycle later it returns fetch_valid=1, fetch_data=16'h0000 (NOP) and fetch_err=1.
REQ-025 Macro IMEM_BOUNDS_CHECK_EN, when not defined: fetch_err is tied to 0 and addresses pass through unchecked.

Structure
REQ-026 Shared package imem_pkg holds: the state enum (IDLE/LOAD/RUN), DEPTH, AW, DW and the NOP constant 16'h0000.
REQ-027 Sub-modules: none; imem_ctrl sits beside instruction_mem and the top level wires we_im, add_im, data_im_in and out_im between them.

Verification
REQ-028 Load: reset, load_start with ld_len=4, four words 16'h1111..16'h4444 with ld_valid held -> four writes at addresses 0..3, load_done one cycle after the 4th word, cpu_run=1.
REQ-029 Fetch: RUN, fetch_req at addresses 0,1,2,3 on consecutive cycles -> fetch_valid on cycles 1..4 with data 1111,2222,3333,4444.
REQ-030 Gapped loader and clamp: ld_valid toggling 1/0 with ld_len=20 -> exactly 16 writes, ld_count stops at 16, RUN entered after the 16th write.
REQ-031 Restart and abort: load_start mid-load after 2 words -> ld_count returns to 0 and rewrites start at address 0; load_start in RUN -> cpu_run drops next cycle.
REQ-032 Reset mid-load: rst after word 2 -> IDLE, we_im=0; a following run_start gives RUN and fetching address 1 returns the previously written word.
REQ-033 Bounds (IMEM_BOUNDS_CHECK_EN defined): fetch_addr=16 -> fetch_valid=1, fetch_data=0000, fetch_err=1, we_im=0; with the macro undefined, fetch_err stays 0.
